// File: rtl/axis_mux_sched_pkg.sv
// Shared definitions for the frame-level AXI-Stream mux scheduler:
// FSM state encoding and the round-robin slot helper.
package axis_mux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } sched_state_e;

  // Port index visited at position 'offset' of a search that starts just after 'last'.
  // last < n and offset < n, so a single wrap subtraction is enough.
  function automatic int unsigned rr_slot(input int unsigned last,
                                          input int unsigned offset,
                                          input int unsigned n);
    int unsigned s;
    s = last + 1 + offset;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module axis_rr_pick
  import axis_mux_sched_pkg::*;
#(
  parameter int S_COUNT   = 4,
  parameter int SEL_WIDTH = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]   req,
  input  logic [SEL_WIDTH-1:0] last,
  output logic                 grant_valid,
  output logic [SEL_WIDTH-1:0] grant_idx
);

  logic [SEL_WIDTH-1:0] slot;

  // Walk from the lowest priority slot up so the nearest requester after 'last' wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    slot        = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      slot = SEL_WIDTH'(rr_slot(32'(last), unsigned'(i), unsigned'(S_COUNT)));
      if (req[slot]) begin
        grant_valid = 1'b1;
        grant_idx   = slot;
      end
    end
  end

endmodule

// File: rtl/axis_mux_sched.sv
// Frame-level scheduler driving enable/sel of a downstream 4-port AXI-Stream mux.
// Grants whole frames round-robin, releases after the tlast beat, counts frames.
module axis_mux_sched
  import axis_mux_sched_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int SEL_WIDTH     = $clog2(S_COUNT),
  parameter int BEAT_WIDTH    = 16,
  parameter int MAX_BEATS     = 1024,
  parameter int GRANT_TIMEOUT = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [S_COUNT-1:0]           port_mask,
  input  logic [S_COUNT-1:0]           mon_tvalid,
  input  logic [S_COUNT-1:0]           mon_tready,
  input  logic [S_COUNT-1:0]           mon_tlast,
  output logic                         enable,
  output logic [SEL_WIDTH-1:0]         sel,
  output logic                         busy,
  output logic [S_COUNT*CNT_WIDTH-1:0] frame_count,
  output logic                         err_len,
  input  logic                         err_clr
);

  localparam int TMO_WIDTH = $clog2(GRANT_TIMEOUT + 1);

  sched_state_e                     state_q, state_d;
  logic [SEL_WIDTH-1:0]             sel_q, sel_d, last_q, last_d;
  logic [TMO_WIDTH-1:0]             tmo_q, tmo_d;
  logic [BEAT_WIDTH-1:0]            beat_q, beat_d, beat_inc;
  logic [S_COUNT-1:0][CNT_WIDTH-1:0] cnt_q;
  logic                             enable_q, busy_q, err_q;
  logic                             frame_done, err_set;
  logic [S_COUNT-1:0]               req;
  logic                             grant_valid;
  logic [SEL_WIDTH-1:0]             grant_idx;
  logic                             beat, beat_last;

  // Handshake: a beat is accepted on a port in any cycle where its tvalid and
  // tready are both high; only the currently selected port is observed.
  assign req       = mon_tvalid & port_mask;
  assign beat      = mon_tvalid[sel_q] & mon_tready[sel_q];
  assign beat_last = mon_tlast[sel_q];
  assign beat_inc  = (beat_q == '1) ? beat_q : beat_q + BEAT_WIDTH'(1);

  axis_rr_pick #(
    .S_COUNT   (S_COUNT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req         (req),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    tmo_d      = tmo_q;
    beat_d     = beat_q;
    frame_done = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          sel_d   = grant_idx;
          tmo_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (beat) begin
          if (beat_last) begin
            state_d    = IDLE;
            last_d     = sel_q;
            frame_done = 1'b1;
          end else begin
            state_d = BUSY;
            beat_d  = BEAT_WIDTH'(1);
            err_set = (MAX_BEATS == 1);
          end
        end else if (tmo_q == TMO_WIDTH'(GRANT_TIMEOUT - 1)) begin
          // Silent grant: the port forfeits its turn.
          state_d = IDLE;
          last_d  = sel_q;
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
      BUSY: begin
        if (beat) begin
          beat_d = beat_inc;
          if (beat_last) begin
            state_d    = IDLE;
            last_d     = sel_q;
            frame_done = 1'b1;
          end else if (beat_inc == BEAT_WIDTH'(MAX_BEATS)) begin
            err_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      last_q   <= SEL_WIDTH'(S_COUNT - 1);
      tmo_q    <= '0;
      beat_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
      beat_q   <= beat_d;
      enable_q <= (state_d == GRANT);
      busy_q   <= (state_d != IDLE);
      err_q    <= err_set | (err_q & ~err_clr);
      if (frame_done) cnt_q[sel_q] <= cnt_q[sel_q] + CNT_WIDTH'(1);
    end
  end

  assign enable      = enable_q;
  assign sel         = sel_q;
  assign busy        = busy_q;
  assign err_len     = err_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_axis_mux_sched.sv
// Randomised scoreboard bench for axis_mux_sched, with a small model of the
// downstream mux and per-port frame sources.
module tb_axis_mux_sched;

  localparam int S  = 4;
  localparam int SW = 2;
  localparam int CW = 16;
  localparam int MB = 8;
  localparam int GT = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S-1:0]    port_mask, mon_tvalid, mon_tready, mon_tlast;
  logic            enable, busy, err_len, err_clr;
  logic [SW-1:0]   sel;
  logic [S*CW-1:0] frame_count;

  always #5 clk = ~clk;

  axis_mux_sched #(
    .S_COUNT(S), .SEL_WIDTH(SW), .BEAT_WIDTH(16), .MAX_BEATS(MB),
    .GRANT_TIMEOUT(GT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port_mask(port_mask), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tlast(mon_tlast), .enable(enable), .sel(sel),
    .busy(busy), .frame_count(frame_count), .err_len(err_len), .err_clr(err_clr)
  );

  int checks = 0;
  int failures = 0;

  logic [SW-1:0] exp_q[$];
  int            frames[S][$];
  int            beat_idx[S];
  int            m_cnt[S];
  logic          m_err;
  int            m_last;
  logic [S-1:0]  stall, phase_mask;
  logic          hold;
  int            hold_port;
  int            rdy_pct;
  logic          clr_req;
  int            run_len;
  logic          run_beat;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic has_work();
    logic w;
    w = 1'b0;
    for (int p = 0; p < S; p++)
      if (phase_mask[p] && !stall[p] && frames[p].size() > 0) w = 1'b1;
    return w;
  endfunction

  // Expected grant order: each arbitration picks the first eligible port after
  // the previous grantee; stalled ports keep their frame and only lose the turn.
  task automatic plan();
    int  rem[S];
    int  q;
    logic any;
    for (int p = 0; p < S; p++) rem[p] = frames[p].size();
    forever begin
      any = 1'b0;
      for (int p = 0; p < S; p++) if (phase_mask[p] && !stall[p] && rem[p] > 0) any = 1'b1;
      if (!any) break;
      q = -1;
      for (int k = 1; k <= S; k++) begin
        if (q < 0 && phase_mask[(m_last + k) % S] && rem[(m_last + k) % S] > 0) q = (m_last + k) % S;
      end
      exp_q.push_back(SW'(q));
      if (!stall[q]) rem[q]--;
      m_last = q;
    end
  endtask

  task automatic drive();
    logic rdy;
    port_mask = has_work() ? phase_mask : '0;
    rdy = ($urandom_range(0, 99) < rdy_pct);
    for (int p = 0; p < S; p++) begin
      mon_tvalid[p] = (frames[p].size() > 0);
      mon_tlast[p]  = 1'b0;
      if (frames[p].size() > 0) mon_tlast[p] = (beat_idx[p] + 1 == frames[p][0]);
      mon_tready[p] = rdy && !stall[p] &&
                      ((enable && sel == SW'(p)) || (hold && hold_port == p));
    end
    err_clr = clr_req;
  endtask

  task automatic step();
    logic set_err;
    set_err = 1'b0;
    @(negedge clk);
    for (int p = 0; p < S; p++) begin
      if (mon_tvalid[p] && mon_tready[p]) begin
        beat_idx[p]++;
        if (beat_idx[p] == 1) begin
          run_beat = 1'b1;
          check("enable_drop_after_first_beat", enable, 0);
        end
        if (beat_idx[p] == frames[p][0]) begin
          hold = 1'b0;
          void'(frames[p].pop_front());
          beat_idx[p] = 0;
          m_cnt[p]++;
          check("frame_count_on_tlast", frame_count[p*CW +: CW], m_cnt[p] % 65536);
          check("idle_after_tlast", busy, 0);
        end else begin
          if (beat_idx[p] == 1) begin
            hold = 1'b1;
            hold_port = p;
          end
          if (beat_idx[p] == MB) set_err = 1'b1;
        end
      end
    end
    m_err = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
    check("err_len", err_len, m_err);
    if (enable) run_len++;
    else begin
      if (run_len > 0 && !run_beat) check("grant_timeout_len", run_len, GT);
      run_len  = 0;
      run_beat = 1'b0;
    end
    drive();
  endtask

  task automatic clear_model();
    for (int p = 0; p < S; p++) begin
      frames[p].delete();
      beat_idx[p] = 0;
      m_cnt[p] = 0;
    end
    exp_q.delete();
    m_err = 1'b0; m_last = S - 1; stall = '0; phase_mask = '0; hold = 1'b0;
    hold_port = 0; clr_req = 1'b0; run_len = 0; run_beat = 1'b0;
    port_mask = '0; mon_tvalid = '0; mon_tready = '0; mon_tlast = '0; err_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check("reset_enable", enable, 0);
    check("reset_sel", sel, 0);
    check("reset_busy", busy, 0);
    check("reset_err_len", err_len, 0);
    check("reset_frame_count", frame_count, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_phase(input logic [S-1:0] mask);
    int budget;
    phase_mask = mask;
    plan();
    budget = 0;
    do begin
      step();
      budget++;
    end while ((has_work() || busy) && budget < 4000);
    if (budget >= 4000) begin
      checks++;
      failures++;
      $display("FAIL phase_budget mask=%b frames_left_busy=%0b", mask, busy);
      apply_reset();
    end else begin
      repeat (3) step();
      check("grants_all_seen", exp_q.size(), 0);
      exp_q.delete();
      for (int p = 0; p < S; p++) check("frame_count_phase_end", frame_count[p*CW +: CW], m_cnt[p]);
      for (int p = 0; p < S; p++) frames[p].delete();
      stall = '0;
      phase_mask = '0;
      step();
    end
  endtask

  // Monitor: every rising enable is a grant and must match the next expected port.
  logic en_prev = 1'b0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && enable && !en_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant actual_sel=%0d expected=none", sel);
      end else begin
        check("grant_sel", sel, exp_q.pop_front());
        check("grant_gap_after_idle", busy_prev, 0);
      end
    end
    en_prev   = enable;
    busy_prev = busy;
  end

  initial begin
    int budget;
    rdy_pct = 100;
    apply_reset();

    // Round-robin over all ports, 3-beat frames, port 0 gets a second frame.
    for (int p = 0; p < S; p++) frames[p].push_back(3);
    frames[0].push_back(3);
    run_phase(4'b1111);
    check("rr_counts", frame_count, 64'h0001_0001_0001_0002);

    // Masked ports 1 and 3 never get a turn.
    for (int p = 0; p < S; p++) begin
      frames[p].push_back(2);
      frames[p].push_back(2);
    end
    run_phase(4'b0101);

    // Single-beat frame on port 1.
    frames[1].push_back(1);
    run_phase(4'b1111);

    // Port 2 granted but never accepted: times out, port 3 goes next.
    stall[2] = 1'b1;
    frames[2].push_back(2);
    frames[3].push_back(2);
    run_phase(4'b1100);

    // Length error boundary: 8 beats is clean, 10 beats flags at beat 8.
    frames[0].push_back(8);
    frames[0].push_back(10);
    run_phase(4'b0001);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();

    // Set and clear in the same cycle: set wins.
    clr_req = 1'b1;
    frames[0].push_back(9);
    run_phase(4'b0001);
    clr_req = 1'b0;
    step();

    // Randomised phases.
    for (int r = 0; r < 8; r++) begin
      rdy_pct = $urandom_range(40, 100);
      for (int p = 0; p < S; p++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) frames[p].push_back($urandom_range(1, 10));
      end
      run_phase(S'($urandom_range(1, 15)));
    end

    // Asynchronous reset in the middle of a frame.
    rdy_pct = 100;
    phase_mask = 4'b0010;
    frames[1].push_back(6);
    plan();
    budget = 0;
    while (beat_idx[1] < 2 && budget < 200) begin
      step();
      budget++;
    end
    check("midframe_reached", beat_idx[1] >= 2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_enable", enable, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_counts", frame_count, 0);
    apply_reset();

    // After reset the first grant goes to port 0.
    for (int p = 0; p < S; p++) frames[p].push_back(2);
    run_phase(4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
